// File: rtl/visuaudio_pkg.sv
// Shared types and constants for the equaliser front panel (menu controller
// and seven-segment decoder).
package visuaudio_pkg;

  localparam int NUM_BANDS  = 6;   // band index range 1..NUM_BANDS
  localparam int GAIN_MAX   = 12;  // gain range -GAIN_MAX..+GAIN_MAX dB
  localparam int OFFSET_MAX = 4;   // offset range 0..OFFSET_MAX

  // cfg_band codes that do not name a single band
  localparam logic [2:0] CFG_BAND_ALL = 3'd0;  // all gains cleared
  localparam logic [2:0] CFG_BAND_OFS = 3'd7;  // offset write

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_MENU   = 3'd2,
    ST_BAND   = 3'd3,
    ST_GAIN   = 3'd4,
    ST_OFFSET = 3'd5
  } ui_state_t;

  typedef enum logic [2:0] {
    MENU_EQ     = 3'd0,
    MENU_OFFSET = 3'd1,
    MENU_RESET  = 3'd2
  } menu_t;

endpackage

// File: rtl/gain_bank.sv
// Per-band signed gain storage with saturating increment/decrement,
// clear-all, a read mux for the selected band and a "will change" flag.
module gain_bank
  import visuaudio_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic [2:0]        i_sel,       // band 1..NUM_BANDS
  output logic signed [4:0] o_gain,      // stored gain of i_sel
  output logic signed [4:0] o_new_gain,  // value written if o_changed
  output logic              o_changed    // inc/dec this cycle alters the gain
);

  localparam logic signed [4:0] G_HI = 5'(GAIN_MAX);
  localparam logic signed [4:0] G_LO = 5'(-GAIN_MAX);

  logic signed [4:0] r_gain [NUM_BANDS];
  logic [2:0]        w_idx;
  logic              w_sel_ok;

  assign w_idx    = i_sel - 3'd1;
  assign w_sel_ok = (i_sel != 3'd0) && (i_sel <= 3'(NUM_BANDS));
  assign o_gain   = w_sel_ok ? r_gain[w_idx] : 5'sd0;

  // Saturation check and next value for the selected band
  always_comb begin
    o_changed  = 1'b0;
    o_new_gain = o_gain;
    if (w_sel_ok && i_inc && (o_gain < G_HI)) begin
      o_changed  = 1'b1;
      o_new_gain = o_gain + 5'sd1;
    end else if (w_sel_ok && i_dec && (o_gain > G_LO)) begin
      o_changed  = 1'b1;
      o_new_gain = o_gain - 5'sd1;
    end
  end

  // Gain storage: clear-all or single-band update
  // NOTE: the gain array is reset explicitly because a mid-operation reset
  // must return every band to 0 dB, so it cannot map to reset-less RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      for (int i = 0; i < NUM_BANDS; i++) r_gain[i] <= 5'sd0;
    end else if (o_changed) begin
      r_gain[w_idx] <= o_new_gain;
    end
  end

endmodule

// File: rtl/eq_menu_ctrl.sv
// Front-panel UI controller: key-driven state machine, menu cursor, band
// select, offset and play toggle, issuing gain/offset config writes.
module eq_menu_ctrl
  import visuaudio_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init_done,
  input  logic        i_key_up,
  input  logic        i_key_down,
  input  logic        i_key_enter,
  input  logic        i_key_back,
  input  logic        i_key_play,
  output logic [2:0]  o_state,
  output logic [2:0]  o_menu_state,
  output logic [2:0]  o_band,
  output logic [31:0] o_gain,
  output logic [2:0]  o_offset,
  output logic        o_play_enable,
  output logic        o_cfg_valid,
  output logic [2:0]  o_cfg_band,
  output logic [4:0]  o_cfg_gain,
  output logic [2:0]  o_cfg_offset
);

  ui_state_t   r_state, w_state_nxt;
  menu_t       r_menu, w_menu_nxt;
  logic [2:0]  r_band, w_band_nxt;
  logic [2:0]  r_offset, w_offset_nxt;
  logic        r_play, w_play_nxt;
  logic        r_cfg_valid, w_cfg_valid_nxt;
  logic [2:0]  r_cfg_band, w_cfg_band_nxt;
  logic [4:0]  r_cfg_gain, w_cfg_gain_nxt;

  logic        w_back, w_enter, w_up, w_down;
  logic        w_gain_inc, w_gain_dec, w_gain_clr, w_gain_changed;
  logic signed [4:0] w_gain, w_new_gain;

  // Navigation priority: back > enter > up > down, one winner per cycle
  assign w_back  = i_key_back;
  assign w_enter = i_key_enter & ~i_key_back;
  assign w_up    = i_key_up & ~i_key_enter & ~i_key_back;
  assign w_down  = i_key_down & ~i_key_up & ~i_key_enter & ~i_key_back;

  gain_bank u_gain_bank (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_gain_clr),
    .i_inc      (w_gain_inc),
    .i_dec      (w_gain_dec),
    .i_sel      (r_band),
    .o_gain     (w_gain),
    .o_new_gain (w_new_gain),
    .o_changed  (w_gain_changed)
  );

  // Next-state and next-output decode
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_menu_nxt      = r_menu;
    w_band_nxt      = r_band;
    w_offset_nxt    = r_offset;
    w_play_nxt      = r_play;
    w_cfg_valid_nxt = 1'b0;
    w_cfg_band_nxt  = r_cfg_band;
    w_cfg_gain_nxt  = r_cfg_gain;
    w_gain_inc      = 1'b0;
    w_gain_dec      = 1'b0;
    w_gain_clr      = 1'b0;

    if (r_state != ST_INIT && i_key_play) w_play_nxt = ~r_play;

    case (r_state)
      ST_INIT: begin
        if (i_init_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_enter) begin
          w_state_nxt = ST_MENU;
          w_menu_nxt  = MENU_EQ;
        end
      end
      ST_MENU: begin
        if (w_back) begin
          w_state_nxt = ST_IDLE;
        end else if (w_enter) begin
          case (r_menu)
            MENU_EQ:     w_state_nxt = ST_BAND;
            MENU_OFFSET: w_state_nxt = ST_OFFSET;
            default: begin
              w_state_nxt     = ST_IDLE;
              w_gain_clr      = 1'b1;
              w_offset_nxt    = 3'd0;
              w_cfg_valid_nxt = 1'b1;
              w_cfg_band_nxt  = CFG_BAND_ALL;
              w_cfg_gain_nxt  = 5'd0;
            end
          endcase
        end else if (w_up) begin
          w_menu_nxt = (r_menu == MENU_RESET) ? MENU_EQ : menu_t'(r_menu + 3'd1);
        end else if (w_down) begin
          w_menu_nxt = (r_menu == MENU_EQ) ? MENU_RESET : menu_t'(r_menu - 3'd1);
        end
      end
      ST_BAND: begin
        if (w_back) begin
          w_state_nxt = ST_MENU;
        end else if (w_enter) begin
          w_state_nxt = ST_GAIN;
        end else if (w_up) begin
          w_band_nxt = (r_band == 3'(NUM_BANDS)) ? 3'd1 : r_band + 3'd1;
        end else if (w_down) begin
          w_band_nxt = (r_band == 3'd1) ? 3'(NUM_BANDS) : r_band - 3'd1;
        end
      end
      ST_GAIN: begin
        if (w_back || w_enter) begin
          w_state_nxt = ST_BAND;
        end else begin
          w_gain_inc = w_up;
          w_gain_dec = w_down;
          if (w_gain_changed) begin
            w_cfg_valid_nxt = 1'b1;
            w_cfg_band_nxt  = r_band;
            w_cfg_gain_nxt  = w_new_gain;
          end
        end
      end
      ST_OFFSET: begin
        if (w_back || w_enter) begin
          w_state_nxt = ST_MENU;
        end else if (w_up && r_offset < 3'(OFFSET_MAX)) begin
          w_offset_nxt    = r_offset + 3'd1;
          w_cfg_valid_nxt = 1'b1;
          w_cfg_band_nxt  = CFG_BAND_OFS;
          w_cfg_gain_nxt  = 5'd0;
        end else if (w_down && r_offset != 3'd0) begin
          w_offset_nxt    = r_offset - 3'd1;
          w_cfg_valid_nxt = 1'b1;
          w_cfg_band_nxt  = CFG_BAND_OFS;
          w_cfg_gain_nxt  = 5'd0;
        end
      end
      default: w_state_nxt = ST_IDLE;  // recover from encodings 6, 7
    endcase
  end

  // State and output registers with synchronous reset
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values and the update order inside the block does not matter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_menu      <= MENU_EQ;
      r_band      <= 3'd1;
      r_offset    <= 3'd0;
      r_play      <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_cfg_band  <= 3'd0;
      r_cfg_gain  <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_menu      <= w_menu_nxt;
      r_band      <= w_band_nxt;
      r_offset    <= w_offset_nxt;
      r_play      <= w_play_nxt;
      r_cfg_valid <= w_cfg_valid_nxt;
      r_cfg_band  <= w_cfg_band_nxt;
      r_cfg_gain  <= w_cfg_gain_nxt;
    end
  end

  assign o_state       = r_state;
  assign o_menu_state  = r_menu;
  assign o_band        = r_band;
  assign o_gain        = {{27{w_gain[4]}}, w_gain};
  assign o_offset      = r_offset;
  assign o_play_enable = r_play;
  assign o_cfg_valid   = r_cfg_valid;
  assign o_cfg_band    = r_cfg_band;
  assign o_cfg_gain    = r_cfg_gain;
  assign o_cfg_offset  = r_offset;

endmodule

// File: tb/tb_eq_menu_ctrl.sv
// Directed self-checking bench for eq_menu_ctrl.
module tb_eq_menu_ctrl;

  localparam logic [4:0] K_NONE  = 5'b00000;
  localparam logic [4:0] K_DOWN  = 5'b00001;
  localparam logic [4:0] K_UP    = 5'b00010;
  localparam logic [4:0] K_ENTER = 5'b00100;
  localparam logic [4:0] K_BACK  = 5'b01000;
  localparam logic [4:0] K_PLAY  = 5'b10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        key_up, key_down, key_enter, key_back, key_play;
  logic [2:0]  state, menu_state, band, offset, cfg_band, cfg_offset;
  logic [31:0] gain;
  logic        play_enable, cfg_valid;
  logic [4:0]  cfg_gain;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes;
  logic [2:0] last_band;
  logic [4:0] last_gain;
  int exp_i;

  always #5 clk = ~clk;

  eq_menu_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_init_done   (init_done),
    .i_key_up      (key_up),
    .i_key_down    (key_down),
    .i_key_enter   (key_enter),
    .i_key_back    (key_back),
    .i_key_play    (key_play),
    .o_state       (state),
    .o_menu_state  (menu_state),
    .o_band        (band),
    .o_gain        (gain),
    .o_offset      (offset),
    .o_play_enable (play_enable),
    .o_cfg_valid   (cfg_valid),
    .o_cfg_band    (cfg_band),
    .o_cfg_gain    (cfg_gain),
    .o_cfg_offset  (cfg_offset)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle key pulse applied on the falling edge, outputs sampled 1 ns
  // after the rising edge that consumes it.
  task automatic step(input logic [4:0] keys);
    @(negedge clk);
    {key_play, key_back, key_enter, key_up, key_down} = keys;
    @(posedge clk);
    #1;
    {key_play, key_back, key_enter, key_up, key_down} = K_NONE;
  endtask

  initial begin
    rst = 1'b1;
    init_done = 1'b0;
    {key_play, key_back, key_enter, key_up, key_down} = K_NONE;
    step(K_NONE);
    step(K_NONE);

    // Reset values
    check("rst_state", 32'(state), 32'd0);
    check("rst_menu", 32'(menu_state), 32'd0);
    check("rst_band", 32'(band), 32'd1);
    check("rst_gain", gain, 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_play", 32'(play_enable), 32'd0);
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst_cfg_band", 32'(cfg_band), 32'd0);
    check("rst_cfg_gain", 32'(cfg_gain), 32'd0);
    check("rst_cfg_offset", 32'(cfg_offset), 32'd0);
    rst = 1'b0;

    // 1: INIT ignores keys until init_done
    for (int i = 0; i < 10; i++) step(K_NONE);
    step(K_UP);
    step(K_ENTER | K_PLAY);
    check("init_hold_state", 32'(state), 32'd0);
    check("init_no_play", 32'(play_enable), 32'd0);
    init_done = 1'b1;
    step(K_NONE);
    check("init_to_idle", 32'(state), 32'd1);

    // 2: IDLE ignores up/down/back; reset menu entry clears everything
    step(K_BACK);
    step(K_UP);
    check("idle_ignore", 32'(state), 32'd1);
    step(K_ENTER);
    check("menu_enter", 32'(state), 32'd2);
    check("menu_start", 32'(menu_state), 32'd0);
    step(K_DOWN);
    check("menu_wrap_down", 32'(menu_state), 32'd2);
    step(K_ENTER);
    check("reset_to_idle", 32'(state), 32'd1);
    check("reset_strobe", 32'(cfg_valid), 32'd1);
    check("reset_cfg_band", 32'(cfg_band), 32'd0);
    check("reset_cfg_gain", 32'(cfg_gain), 32'd0);
    check("reset_cfg_offset", 32'(cfg_offset), 32'd0);
    check("reset_gain", gain, 32'd0);
    check("reset_offset", 32'(offset), 32'd0);
    step(K_NONE);
    check("reset_strobe_1cyc", 32'(cfg_valid), 32'd0);

    // 3: band 3 gain up to saturation
    step(K_ENTER);
    check("menu_reenter", 32'(menu_state), 32'd0);
    step(K_ENTER);
    check("to_band", 32'(state), 32'd3);
    step(K_UP);
    step(K_UP);
    check("band_sel", 32'(band), 32'd3);
    step(K_ENTER);
    check("to_gain", 32'(state), 32'd4);
    strobes = 0;
    for (int i = 1; i <= 13; i++) begin
      step(K_UP);
      exp_i = (i > 12) ? 12 : i;
      check("gain_up", gain, 32'(exp_i));
      check("gain_up_strobe", 32'(cfg_valid), (i <= 12) ? 32'd1 : 32'd0);
      if (cfg_valid) begin
        strobes++;
        last_band = cfg_band;
        last_gain = cfg_gain;
      end
    end
    check("gain_up_count", 32'(strobes), 32'd12);
    check("gain_up_last_band", 32'(last_band), 32'd3);
    check("gain_up_last_gain", 32'(last_gain), 32'd12);

    // 4: down to -12 and hold; other band untouched
    strobes = 0;
    for (int i = 1; i <= 25; i++) begin
      step(K_DOWN);
      exp_i = (12 - i < -12) ? -12 : 12 - i;
      check("gain_down", gain, 32'(exp_i));
      if (cfg_valid) begin
        strobes++;
        last_gain = cfg_gain;
      end
    end
    check("gain_down_min", gain, 32'hFFFF_FFF4);
    check("gain_down_count", 32'(strobes), 32'd24);
    check("gain_down_last", 32'(last_gain), 32'h14);
    step(K_BACK);
    check("gain_back", 32'(state), 32'd3);
    step(K_UP);
    check("band4", 32'(band), 32'd4);
    check("band4_gain", gain, 32'd0);
    step(K_DOWN);
    check("band3_kept", gain, 32'hFFFF_FFF4);
    step(K_BACK);
    check("band_back", 32'(state), 32'd2);
    check("band_back_menu", 32'(menu_state), 32'd0);

    // 5: offset saturation both ways, enter beats up
    step(K_UP);
    step(K_ENTER);
    check("to_offset", 32'(state), 32'd5);
    strobes = 0;
    for (int i = 1; i <= 5; i++) begin
      step(K_UP);
      check("ofs_up", 32'(offset), (i > 4) ? 32'd4 : 32'(i));
      if (cfg_valid) begin
        strobes++;
        check("ofs_cfg_band", 32'(cfg_band), 32'd7);
        check("ofs_cfg_offset", 32'(cfg_offset), 32'(i));
        check("ofs_cfg_gain", 32'(cfg_gain), 32'd0);
      end
    end
    check("ofs_up_count", 32'(strobes), 32'd4);
    for (int i = 1; i <= 5; i++) begin
      step(K_DOWN);
      check("ofs_down", 32'(offset), (4 - i < 0) ? 32'd0 : 32'(4 - i));
    end
    step(K_ENTER | K_UP);
    check("ofs_enter_prio", 32'(state), 32'd2);
    check("ofs_enter_keep", 32'(offset), 32'd0);
    check("ofs_menu_keep", 32'(menu_state), 32'd1);

    // 6: play with same-cycle back in GAIN, then mid-GAIN reset
    step(K_DOWN);
    step(K_ENTER);
    step(K_ENTER);
    check("gain2_state", 32'(state), 32'd4);
    step(K_UP);
    check("gain2_up", gain, 32'hFFFF_FFF5);
    step(K_PLAY | K_BACK);
    check("play_on", 32'(play_enable), 32'd1);
    check("play_back", 32'(state), 32'd3);
    step(K_ENTER);
    step(K_UP);
    check("gain3_up", gain, 32'hFFFF_FFF6);
    rst = 1'b1;
    step(K_NONE);
    rst = 1'b0;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_play", 32'(play_enable), 32'd0);
    check("mid_rst_band", 32'(band), 32'd1);
    check("mid_rst_gain", gain, 32'd0);
    step(K_NONE);
    check("mid_rst_idle", 32'(state), 32'd1);
    step(K_ENTER);
    step(K_ENTER);
    step(K_UP);
    step(K_UP);
    check("mid_rst_band3_gain", gain, 32'd0);
    step(K_BACK | K_ENTER | K_UP);
    check("back_prio_state", 32'(state), 32'd2);
    check("back_prio_band", 32'(band), 32'd3);
    step(K_PLAY);
    check("play_menu", 32'(play_enable), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
